dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core. It is the memory side of the datapath's load/store port (address, write data, read data).
- Accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word access with RV32I sign/zero extension and returns read data or an error over a valid/ready response channel.
- Sits between the Memory stage and the word-organised data RAM; later stall logic consumes req_ready/rsp_valid.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: wait-state cycles between request acceptance and response, 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned (rs2 value)
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range, or illegal funct3

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request cleared.
  - req_ready=0 while reset is low.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE) && reset.
  - rsp_valid = 1 only in RESP.
- IDLE: when req_valid && req_ready:
  - capture we, funct3, addr, wdata;
  - load counter with LATENCY;
  - go to WAIT if LATENCY>0, otherwise go to RESP.
- WAIT: counter decrements each cycle. When the counter is 1, go to RESP on the next edge.
- Commit edge: the edge entering RESP.
  - Store: the memory write happens on this edge.
  - Load: rsp_rdata and rsp_err are registered on this edge.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the acceptance edge.
- RESP: rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1. On the handshake edge, go to IDLE and clear rsp_valid.
  - No new request is accepted in the same cycle; maximum throughput is one request per LATENCY+2 cycles.
- Error conditions; any one sets rsp_err=1, suppresses the write, and forces rsp_rdata=0:
  - word address addr[31:2] >= DEPTH_WORDS;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {3,6,7};
  - store funct3 > 2.
- Word index: addr[$clog2(DEPTH_WORDS)+1:2]. Byte lane: addr[1:0].
- Loads:
  - LB (0): sign-extend the selected byte.
  - LH (1): sign-extend the selected half (lane 0 or 2).
  - LW (2): full word.
  - LBU (4): zero-extend the selected byte.
  - LHU (5): zero-extend the selected half.
- Stores:
  - SB (0): wdata[7:0] goes into the selected byte only.
  - SH (1): wdata[15:0] goes into the selected half only.
  - SW (2): full word.
  - Untouched bytes keep their prior value.
  - rsp_rdata=0 for all stores.
- Reset during WAIT: request aborted, no write performed, no response.
- Reset during RESP: response dropped; the store had already committed and stays committed.
- req_* inputs are ignored outside the IDLE acceptance edge.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - funct3 localparams F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
- Sub-module dmem_lane_align, purely combinational:
  - inputs: funct3, addr[1:0], stored word, wdata;
  - outputs: extended load data, merged store word, 4-bit byte-enable, misalign/illegal flag.
- The top level owns the FSM, counter, and memory array.

Test Plan:
- After reset, with LATENCY=2: SW addr 0x10, data 0xDEADBEEF, then LW 0x10. rsp_valid rises 3 cycles after each acceptance; rdata=0xDEADBEEF, err=0.
- SB 0x11 data 0x000000A5 over word 0x11223344 at 0x10, then LW 0x10 -> 0x1122A544. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5.
- Word 0x8001_7FFF at 0x20: LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x20 -> 0x00007FFF.
- Errors:
  - LW 0x13 -> err=1, rdata=0.
  - SH 0x21 -> err=1, word unchanged.
  - LW 4*DEPTH_WORDS -> err=1.
  - Load funct3=3 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid, rdata and err stay stable; req_ready stays 0; a req_valid pulse is ignored. The handshake then returns the FSM to IDLE.
- Reset:
  - reset=0 during WAIT of SW 0x30 -> word at 0x30 unchanged, rsp_valid never asserts.
  - With LATENCY=0, rsp_valid asserts 1 cycle after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and RV32I load/store funct3 encodings for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: extends load data, merges store data into the stored word and
// flags misaligned or illegal funct3 accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  byte_en,
    output logic        bad
);

    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] wrep;

    always_comb begin
        bsel       = rword[{lane, 3'b000} +: 8];
        hsel       = lane[1] ? rword[31:16] : rword[15:0];
        load_data  = '0;
        byte_en    = '0;
        wrep       = wdata;
        bad        = 1'b0;
        store_word = rword;
        if (we) begin
            case (funct3)
                F3_B: begin
                    byte_en = 4'b0001 << lane;
                    wrep    = {4{wdata[7:0]}};
                end
                F3_H: begin
                    byte_en = lane[1] ? 4'b1100 : 4'b0011;
                    wrep    = {2{wdata[15:0]}};
                    bad     = lane[0];
                end
                F3_W: begin
                    byte_en = 4'b1111;
                    bad     = |lane;
                end
                default: bad = 1'b1;
            endcase
            if (bad) begin
                byte_en = '0;
            end
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    store_word[8*i +: 8] = wrep[8*i +: 8];
                end
            end
        end else begin
            case (funct3)
                F3_B:  load_data = {{24{bsel[7]}}, bsel};
                F3_BU: load_data = {24'd0, bsel};
                F3_H: begin
                    load_data = {{16{hsel[15]}}, hsel};
                    bad       = lane[0];
                end
                F3_HU: begin
                    load_data = {16'd0, hsel};
                    bad       = lane[0];
                end
                F3_W: begin
                    load_data = rword;
                    bad       = |lane;
                end
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, registered response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [2:0]    cap_funct3;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          cur_we;
    logic [2:0]    cur_funct3;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0]   rword;
    logic [31:0]   load_data;
    logic [31:0]   store_word;
    logic [3:0]    byte_en;
    logic          bad;
    logic          err;
    logic          commit;

    // With zero wait states the commit happens on the acceptance edge, so steer the live request.
    assign cur_we     = (state == IDLE) ? req_we     : cap_we;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
    assign cur_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;

    assign word_idx = cur_addr[AW+1:2];
    assign rword    = mem[word_idx];
    assign err      = (|cur_addr[31:AW+2]) | bad;
    assign commit   = reset && (((state == IDLE) && req_valid && (LATENCY == 0)) ||
                                ((state == WAIT) && (cnt == 4'd1)));

    assign req_ready = (state == IDLE) && reset;

    dmem_lane_align u_align (
        .we        (cur_we),
        .funct3    (cur_funct3),
        .lane      (cur_addr[1:0]),
        .rword     (rword),
        .wdata     (cur_wdata),
        .load_data (load_data),
        .store_word(store_word),
        .byte_en   (byte_en),
        .bad       (bad)
    );

    always_ff @(posedge clk) begin
        if (commit && cur_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cnt        <= LAT4;
                        state      <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (cur_we || err) ? 32'd0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [2:0]  z_req_funct3;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_zero (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_funct3 = '0; z_req_addr = '0;
        z_req_wdata = '0; z_rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        xact("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("sw10b", 1'b1, F3_W, 32'h10, 32'h11223344, 32'h0, 1'b0);
        xact("sb11", 1'b1, F3_B, 32'h11, 32'h000000A5, 32'h0, 1'b0);
        xact("lw10c", 1'b0, F3_W, 32'h10, 32'h0, 32'h1122A544, 1'b0);
        xact("lb11", 1'b0, F3_B, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0);
        xact("lbu11", 1'b0, F3_BU, 32'h11, 32'h0, 32'h000000A5, 1'b0);
        xact("lb13", 1'b0, F3_B, 32'h13, 32'h0, 32'h00000011, 1'b0);

        xact("sw20", 1'b1, F3_W, 32'h20, 32'h80017FFF, 32'h0, 1'b0);
        xact("lh22", 1'b0, F3_H, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        xact("lhu22", 1'b0, F3_HU, 32'h22, 32'h0, 32'h00008001, 1'b0);
        xact("lh20", 1'b0, F3_H, 32'h20, 32'h0, 32'h00007FFF, 1'b0);
        xact("sh22", 1'b1, F3_H, 32'h22, 32'hFFFF1234, 32'h0, 1'b0);
        xact("lw20", 1'b0, F3_W, 32'h20, 32'h0, 32'h12347FFF, 1'b0);

        xact("lw13_err", 1'b0, F3_W, 32'h13, 32'h0, 32'h0, 1'b1);
        xact("sh21_err", 1'b1, F3_H, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact("s3_err", 1'b1, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1);
        xact("lw20_keep", 1'b0, F3_W, 32'h20, 32'h0, 32'h12347FFF, 1'b0);
        xact("lw_oor", 1'b0, F3_W, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        xact("sw_oor", 1'b1, F3_W, 32'(4 * DEPTH) + 32'h10, 32'h0, 32'h0, 1'b1);
        xact("lw10_keep", 1'b0, F3_W, 32'h10, 32'h0, 32'h1122A544, 1'b0);
        xact("l3_err", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        xact("lhu21_err", 1'b0, F3_HU, 32'h21, 32'h0, 32'h0, 1'b1);

        // Response backpressure with a stray store request that must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", rsp_rdata, 32'h1122A544);
            check("bp_hold_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            if (i == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_wdata = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        xact("bp_after", 1'b0, F3_W, 32'h10, 32'h0, 32'h1122A544, 1'b0);

        // Reset while a store waits: no write, no response.
        xact("sw30", 1'b1, F3_W, 32'h30, 32'h12345678, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h30;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= rsp_valid;
        end
        check("rstwait_no_rsp", 32'(seen), 32'd0);
        xact("lw30_keep", 1'b0, F3_W, 32'h30, 32'h0, 32'h12345678, 1'b0);

        // Zero wait states: response one cycle after acceptance.
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_funct3 = F3_W; z_req_addr = 32'h40;
        z_req_wdata = 32'h0BADF00D;
        #1;
        check("z_req_ready", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("z_sw_valid", 32'(z_rsp_valid), 32'd1);
        check("z_sw_err", 32'(z_rsp_err), 32'd0);
        z_rsp_ready = 1'b1;
        @(posedge clk); #1;
        z_rsp_ready = 1'b0;
        check("z_sw_drop", 32'(z_rsp_valid), 32'd0);
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_funct3 = F3_HU; z_req_addr = 32'h42;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        check("z_lhu_valid", 32'(z_rsp_valid), 32'd1);
        check("z_lhu_rdata", z_rsp_rdata, 32'h00000BAD);
        z_rsp_ready = 1'b1;
        @(posedge clk); #1;
        z_rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
